fetch_unit: RTL and testbench

Instruction fetch front end that sits directly upstream of the single-cycle datapath. It owns the program counter and issues word-aligned requests to a synchronous instruction memory with 1-cycle read latency. It buffers returned instructions with their PC in a small FIFO and presents them to decode/execute through a valid/ready handshake. Branch/jump redirects flush the buffer and discard in-flight fetches.

---
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues word reads to a 1-cycle
// synchronous instruction memory and buffers {instr, pc} in a small FIFO.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic [31:0] ImemData,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] OutInstr,
    output logic [31:0] OutPC,
    output logic [31:0] OutPCPlus4
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic          inflight;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];

    logic          valid_c;
    logic          pop_c;
    logic          push_c;
    logic          issue_c;
    logic [CW:0]   occ_c;
    logic          unused_redirect_lsbs;

    assign unused_redirect_lsbs = &{1'b0, RedirectPC[1:0]};

    // Occupancy counts the in-flight word so a returning fetch always has room.
    assign valid_c = (count != '0) & ~Redirect;
    assign pop_c   = valid_c & OutReady;
    assign push_c  = inflight & ~Redirect;
    assign occ_c   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop_c);
    assign issue_c = Reset & ~Redirect & (occ_c < (CW+1)'(DEPTH));

    assign ImemReq    = issue_c;
    assign ImemAddr   = fetch_pc;
    assign OutValid   = valid_c;
    assign OutInstr   = valid_c ? instr_mem[rd_ptr] : 32'h0;
    assign OutPC      = valid_c ? pc_mem[rd_ptr] : 32'h0;
    assign OutPCPlus4 = valid_c ? (pc_mem[rd_ptr] + 32'd4) : 32'h0;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= 32'h0;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= 32'h0;
                pc_mem[i]    <= 32'h0;
            end
        end else if (Redirect) begin
            // Flush buffer and drop the word that returns this cycle.
            fetch_pc <= {RedirectPC[31:2], 2'b00};
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= issue_c;
            if (issue_c) begin
                fetch_pc <= fetch_pc + 32'd4;
                req_pc   <= fetch_pc;
            end
            if (push_c) begin
                instr_mem[wr_ptr] <= ImemData;
                pc_mem[wr_ptr]    <= req_pc;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run,
// all compared against a queue-based model of issued-but-unconsumed fetches.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .Clock(clk), .Reset(rst_n), .Redirect(redirect), .RedirectPC(redirect_pc),
        .ImemReq(imem_req), .ImemAddr(imem_addr), .ImemData(imem_data),
        .OutValid(out_valid), .OutReady(out_ready), .OutInstr(out_instr),
        .OutPC(out_pc), .OutPCPlus4(out_pc_plus4)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a >> 2;
    endfunction

    // Instruction memory: 1-cycle latency, garbage when no request was made.
    always @(posedge clk) imem_data <= imem_req ? mem_word(imem_addr) : $urandom;

    // Reference model: every issued fetch becomes visible two cycles later and
    // leaves on pop; reset/redirect discard everything outstanding.
    typedef struct { logic [31:0] pc; int ready; } ent_t;
    ent_t        q[$];
    logic [31:0] m_pc = RESET_PC;
    int          cyc = 0;
    logic        exp_req, exp_valid, exp_pop;
    logic [31:0] exp_addr, exp_pc, exp_instr, exp_plus4;

    task automatic drive(input logic r, input logic rd, input logic [31:0] rp, input logic rdy);
        rst_n = r; redirect = rd; redirect_pc = rp; out_ready = rdy;
        #1;
        exp_valid = 1'b0;
        if (!rd && q.size() > 0) exp_valid = (q[0].ready <= cyc);
        exp_pop  = exp_valid && rdy;
        exp_req  = r && !rd && ((q.size() - int'(exp_pop)) < DEPTH);
        exp_addr = m_pc;
        exp_pc = 32'h0; exp_instr = 32'h0; exp_plus4 = 32'h0;
        if (exp_valid) begin
            exp_pc    = q[0].pc;
            exp_instr = mem_word(q[0].pc);
            exp_plus4 = q[0].pc + 32'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_pc = RESET_PC;
        end else if (redirect) begin
            q.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (exp_pop) void'(q.pop_front());
            if (exp_req) begin
                q.push_back('{pc: m_pc, ready: cyc + 2});
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        n_total++; if (imem_req !== 1'b0) $display("FAIL reset_req got %b exp 0", imem_req); else n_pass++;
        n_total++; if (imem_addr !== RESET_PC) $display("FAIL reset_addr got %h exp %h", imem_addr, RESET_PC); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else n_pass++;
        n_total++; if ({out_instr, out_pc, out_pc_plus4} !== 96'h0) $display("FAIL reset_outs got %h/%h/%h exp 0", out_instr, out_pc, out_pc_plus4); else n_pass++;
        tick();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1);
            n_total++; if (out_valid !== (i >= 2)) $display("FAIL stream_valid c%0d got %b exp %b", i, out_valid, i >= 2); else n_pass++;
            n_total++; if (imem_req !== exp_req) $display("FAIL stream_req c%0d got %b exp %b", i, imem_req, exp_req); else n_pass++;
            n_total++; if (imem_addr !== exp_addr) $display("FAIL stream_addr c%0d got %h exp %h", i, imem_addr, exp_addr); else n_pass++;
            if (i >= 2) begin
                n_total++; if (out_pc !== RESET_PC + 32'(4 * (i - 2))) $display("FAIL stream_pc c%0d got %h exp %h", i, out_pc, RESET_PC + 32'(4 * (i - 2))); else n_pass++;
                n_total++; if (out_instr !== exp_instr) $display("FAIL stream_instr c%0d got %h exp %h", i, out_instr, exp_instr); else n_pass++;
                n_total++; if (out_pc_plus4 !== out_pc + 32'd4) $display("FAIL stream_plus4 c%0d got %h exp %h", i, out_pc_plus4, out_pc + 32'd4); else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_stall();
        int nreq;
        do_reset();
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0);
            if (imem_req === 1'b1) nreq++;
            tick();
        end
        n_total++; if (nreq != DEPTH) $display("FAIL stall_reqs got %0d exp %0d", nreq, DEPTH); else n_pass++;
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        n_total++; if (imem_addr !== RESET_PC + 32'd16) $display("FAIL stall_addr got %h exp %h", imem_addr, RESET_PC + 32'd16); else n_pass++;
        n_total++; if (imem_req !== 1'b0) $display("FAIL stall_req got %b exp 0", imem_req); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1);
            n_total++; if (out_valid !== 1'b1 || out_pc !== RESET_PC + 32'(4 * i))
                $display("FAIL stall_resume c%0d got v=%b pc=%h exp v=1 pc=%h", i, out_valid, out_pc, RESET_PC + 32'(4 * i));
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 32'h0000_0103, 1'b1);
        n_total++; if (out_valid !== 1'b0) $display("FAIL redir_valid got %b exp 0", out_valid); else n_pass++;
        n_total++; if (imem_req !== 1'b0) $display("FAIL redir_req got %b exp 0", imem_req); else n_pass++;
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) $display("FAIL redir_target got req=%b addr=%h exp req=1 addr=00000100", imem_req, imem_addr); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL redir_stale1 got %b exp 0", out_valid); else n_pass++;
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        n_total++; if (out_valid !== 1'b0) $display("FAIL redir_stale2 got %b exp 0", out_valid); else n_pass++;
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1);
            n_total++; if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(4 * i) || out_instr !== 32'h40 + 32'(i))
                $display("FAIL redir_out c%0d got v=%b pc=%h instr=%h exp pc=%h", i, out_valid, out_pc, out_instr, 32'h100 + 32'(4 * i));
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        n_total++; if (out_valid !== 1'b1 || imem_req !== 1'b1) $display("FAIL full_pop_issue got v=%b req=%b exp 1/1", out_valid, imem_req); else n_pass++;
        n_total++; if (imem_addr !== RESET_PC + 32'd16) $display("FAIL full_addr got %h exp %h", imem_addr, RESET_PC + 32'd16); else n_pass++;
        tick();
        for (int i = 1; i < 7; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1);
            n_total++; if (out_valid !== 1'b1 || out_pc !== RESET_PC + 32'(4 * i))
                $display("FAIL full_order c%0d got v=%b pc=%h exp pc=%h", i, out_valid, out_pc, RESET_PC + 32'(4 * i));
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_wrap();
        drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1);
            tick();
        end
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        n_total++; if (out_pc !== 32'hFFFF_FFFC || out_pc_plus4 !== 32'h0 || out_instr !== 32'h3FFF_FFFF)
            $display("FAIL wrap_top got pc=%h p4=%h instr=%h exp fffffffc/00000000/3fffffff", out_pc, out_pc_plus4, out_instr);
        else n_pass++;
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        n_total++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_pc_plus4 !== 32'h4)
            $display("FAIL wrap_next got v=%b pc=%h p4=%h exp 1/00000000/00000004", out_valid, out_pc, out_pc_plus4);
        else n_pass++;
        tick();
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1);
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        n_total++; if (out_valid !== 1'b0 || {out_instr, out_pc, out_pc_plus4} !== 96'h0)
            $display("FAIL mrst_outs got v=%b %h/%h/%h exp 0", out_valid, out_instr, out_pc, out_pc_plus4);
        else n_pass++;
        n_total++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) $display("FAIL mrst_req got req=%b addr=%h exp 1/%h", imem_req, imem_addr, RESET_PC); else n_pass++;
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        n_total++; if (out_valid !== 1'b0) $display("FAIL mrst_stale got %b exp 0", out_valid); else n_pass++;
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        n_total++; if (out_valid !== 1'b1 || out_pc !== RESET_PC || out_instr !== mem_word(RESET_PC))
            $display("FAIL mrst_first got v=%b pc=%h instr=%h exp pc=%h", out_valid, out_pc, out_instr, RESET_PC);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        logic        r, rd, rdy;
        logic [31:0] rp;
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(99) != 0);
            rd  = ($urandom_range(19) == 0);
            rp  = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(15)) : $urandom;
            rdy = ($urandom_range(2) != 0);
            drive(r, rd, rp, rdy);
            n_total++; if (imem_req !== exp_req) $display("FAIL rnd_req c%0d got %b exp %b", cyc, imem_req, exp_req); else n_pass++;
            n_total++; if (imem_addr !== exp_addr) $display("FAIL rnd_addr c%0d got %h exp %h", cyc, imem_addr, exp_addr); else n_pass++;
            n_total++; if (out_valid !== exp_valid) $display("FAIL rnd_valid c%0d got %b exp %b", cyc, out_valid, exp_valid); else n_pass++;
            n_total++; if (out_pc !== exp_pc) $display("FAIL rnd_pc c%0d got %h exp %h", cyc, out_pc, exp_pc); else n_pass++;
            n_total++; if (out_instr !== exp_instr) $display("FAIL rnd_instr c%0d got %h exp %h", cyc, out_instr, exp_instr); else n_pass++;
            n_total++; if (out_pc_plus4 !== exp_plus4) $display("FAIL rnd_plus4 c%0d got %h exp %h", cyc, out_pc_plus4, exp_plus4); else n_pass++;
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
        do_reset();
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_full_pop();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
